// File: rtl/video_mode_sequencer.sv
// Video mode sequencer: owns the sink's timing parameters, reloads them on a frame
// boundary under sink reset, and monitors late cycles. VIDEO_MODE_INTERLACE_EN adds mode 4.
module video_mode_sequencer #(
   parameter int DEFAULT_MODE    = 0,
   parameter int RESET_CYCLES    = 16,
   parameter int WAIT_TIMEOUT    = 2000000,
   parameter int BAD_FRAME_LIMIT = 4
) (
   input  logic        pixelClock,
   input  logic        reset,
   input  logic [2:0]  modeSelect,
   input  logic        modeChangeRequest,
   input  logic        sinkVSync,
   input  logic        sinkLate,
   output logic [6:0]  hFrontPorch,
   output logic [7:0]  hSyncPulse,
   output logic [7:0]  hBackPorch,
   output logic [10:0] hActive,
   output logic [5:0]  vFrontPorch,
   output logic [3:0]  vSyncPulse,
   output logic [5:0]  vBackPorch,
   output logic [10:0] vActive,
   output logic        syncIsActiveLow,
   output logic        isInterlaced,
   output logic        sinkReset,
   output logic        busy,
   output logic [2:0]  currentMode,
   output logic        modeChanged,
   output logic        modeError,
   output logic [15:0] lateCount,
   output logic        underrun
);

   typedef struct packed {
      logic [6:0]  hfp;
      logic [7:0]  hsync;
      logic [7:0]  hbp;
      logic [10:0] hact;
      logic [5:0]  vfp;
      logic [3:0]  vsync;
      logic [5:0]  vbp;
      logic [10:0] vact;
      logic        low;
      logic        intl;
   } mode_t;

   typedef enum logic [1:0] {HOLD, RUN, WAIT_VSYNC} state_t;

`ifdef VIDEO_MODE_INTERLACE_EN
   localparam int NUM_MODES = 5;
`else
   localparam int NUM_MODES = 4;
`endif
   localparam logic [2:0]  DEF_IDX   = (DEFAULT_MODE >= 0 && DEFAULT_MODE < NUM_MODES) ?
                                       3'(DEFAULT_MODE) : 3'd0;
   localparam logic [31:0] HOLD_LAST = 32'(RESET_CYCLES - 1);
   localparam logic [31:0] WAIT_LAST = 32'(WAIT_TIMEOUT - 1);
   localparam logic [15:0] BAD_LIM   = 16'(BAD_FRAME_LIMIT);

   function automatic mode_t mode_entry(input logic [2:0] idx);
      case (idx)
         3'd1:    return '{7'd40,  8'd128, 8'd88,  11'd800,  6'd1, 4'd4, 6'd23, 11'd600, 1'b0, 1'b0};
         3'd2:    return '{7'd110, 8'd40,  8'd220, 11'd1280, 6'd5, 4'd5, 6'd20, 11'd720, 1'b0, 1'b0};
         3'd3:    return '{7'd16,  8'd62,  8'd60,  11'd720,  6'd9, 4'd6, 6'd30, 11'd480, 1'b1, 1'b0};
`ifdef VIDEO_MODE_INTERLACE_EN
         3'd4:    return '{7'd88,  8'd44,  8'd148, 11'd1920, 6'd2, 4'd5, 6'd15, 11'd540, 1'b0, 1'b1};
`endif
         default: return '{7'd16,  8'd96,  8'd48,  11'd640,  6'd10, 4'd2, 6'd33, 11'd480, 1'b1, 1'b0};
      endcase
   endfunction

   function automatic logic idx_valid(input logic [2:0] idx);
      return 32'(idx) < NUM_MODES;
   endfunction

   state_t      state, state_n;
   logic [31:0] cnt;
   logic [2:0]  pending;
   mode_t       cfg;
   logic        vact_q;
   logic [15:0] acc;
   logic [15:0] bad_cnt;

   logic        vact, boundary, req_ok, enter_hold;
   logic [16:0] acc_sum;
   logic [15:0] lat;
   logic [15:0] bad_inc;

   // Frame boundary uses the polarity of the currently loaded mode.
   assign vact       = sinkVSync ^ cfg.low;
   assign boundary   = vact & ~vact_q & (state != HOLD);
   assign req_ok     = modeChangeRequest & idx_valid(modeSelect);
   assign enter_hold = (state_n == HOLD) && (state != HOLD);
   assign acc_sum    = {1'b0, acc} + {16'd0, sinkLate};
   assign lat        = acc_sum[16] ? 16'hFFFF : acc_sum[15:0];
   assign bad_inc    = (bad_cnt == 16'hFFFF) ? bad_cnt : bad_cnt + 16'd1;

   always_ff @(posedge pixelClock or posedge reset) begin
      if (reset) state <= HOLD;
      else       state <= state_n;
   end

   always_comb begin
      state_n   = state;
      sinkReset = 1'b0;
      busy      = 1'b1;
      case (state)
         HOLD: begin
            sinkReset = 1'b1;
            if (cnt == HOLD_LAST) state_n = RUN;
         end
         RUN: begin
            busy = 1'b0;
            if (req_ok) state_n = WAIT_VSYNC;
         end
         WAIT_VSYNC: begin
            if (boundary || cnt == WAIT_LAST) state_n = HOLD;
         end
         default: state_n = HOLD;
      endcase
   end

   always_ff @(posedge pixelClock or posedge reset) begin
      if (reset) begin
         cnt         <= '0;
         pending     <= DEF_IDX;
         cfg         <= mode_entry(DEF_IDX);
         currentMode <= DEF_IDX;
         modeChanged <= 1'b0;
         modeError   <= 1'b0;
         vact_q      <= 1'b0;
         acc         <= '0;
         bad_cnt     <= '0;
         lateCount   <= '0;
         underrun    <= 1'b0;
      end else begin
         cnt         <= (state_n != state || state == RUN) ? '0 : cnt + 32'd1;
         modeChanged <= (state == HOLD) && (state_n == RUN);
         modeError   <= (state == RUN) && modeChangeRequest && !idx_valid(modeSelect);
         vact_q      <= vact;
         if (state == RUN && req_ok) pending <= modeSelect;
         // New parameters appear together with sinkReset on the first HOLD cycle.
         if (enter_hold) begin
            cfg         <= mode_entry(pending);
            currentMode <= pending;
         end
         if (boundary) lateCount <= lat;
         if (enter_hold) begin
            acc      <= '0;
            bad_cnt  <= '0;
            underrun <= 1'b0;
         end else if (boundary) begin
            acc <= '0;
            if (lat != 16'd0) begin
               bad_cnt <= bad_inc;
               if (bad_inc >= BAD_LIM) underrun <= 1'b1;
            end else begin
               bad_cnt <= '0;
            end
         end else if (state == RUN && sinkLate && acc != 16'hFFFF) begin
            acc <= acc + 16'd1;
         end
      end
   end

   assign hFrontPorch     = cfg.hfp;
   assign hSyncPulse      = cfg.hsync;
   assign hBackPorch      = cfg.hbp;
   assign hActive         = cfg.hact;
   assign vFrontPorch     = cfg.vfp;
   assign vSyncPulse      = cfg.vsync;
   assign vBackPorch      = cfg.vbp;
   assign vActive         = cfg.vact;
   assign syncIsActiveLow = cfg.low;
   assign isInterlaced    = cfg.intl;

endmodule

// File: tb/tb_video_mode_sequencer.sv
// Bench for video_mode_sequencer: mode loads are scoreboarded (expected mode pushed on
// request, compared on each modeChanged pulse); other behaviour is checked inline per task.
module tb_video_mode_sequencer;
   logic        pixelClock = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  modeSelect = 3'd0;
   logic        modeChangeRequest = 1'b0;
   logic        sinkVSync = 1'b1;
   logic        sinkLate = 1'b0;
   logic [6:0]  hFrontPorch;
   logic [7:0]  hSyncPulse;
   logic [7:0]  hBackPorch;
   logic [10:0] hActive;
   logic [5:0]  vFrontPorch;
   logic [3:0]  vSyncPulse;
   logic [5:0]  vBackPorch;
   logic [10:0] vActive;
   logic        syncIsActiveLow;
   logic        isInterlaced;
   logic        sinkReset;
   logic        busy;
   logic [2:0]  currentMode;
   logic        modeChanged;
   logic        modeError;
   logic [15:0] lateCount;
   logic        underrun;

   int tests = 0, fails = 0;
   int sb_tests = 0, sb_fails = 0;
   int exp_q[$];

   video_mode_sequencer #(.DEFAULT_MODE(0), .RESET_CYCLES(16), .WAIT_TIMEOUT(100),
                          .BAD_FRAME_LIMIT(4)) dut (
      .pixelClock(pixelClock), .reset(reset), .modeSelect(modeSelect),
      .modeChangeRequest(modeChangeRequest), .sinkVSync(sinkVSync), .sinkLate(sinkLate),
      .hFrontPorch(hFrontPorch), .hSyncPulse(hSyncPulse), .hBackPorch(hBackPorch),
      .hActive(hActive), .vFrontPorch(vFrontPorch), .vSyncPulse(vSyncPulse),
      .vBackPorch(vBackPorch), .vActive(vActive), .syncIsActiveLow(syncIsActiveLow),
      .isInterlaced(isInterlaced), .sinkReset(sinkReset), .busy(busy),
      .currentMode(currentMode), .modeChanged(modeChanged), .modeError(modeError),
      .lateCount(lateCount), .underrun(underrun));

   always #5 pixelClock = ~pixelClock;

   function automatic logic [62:0] exp_vec(input int m);
      case (m)
         1:       return {7'd40,  8'd128, 8'd88,  11'd800,  6'd1,  4'd4, 6'd23, 11'd600, 1'b0, 1'b0};
         2:       return {7'd110, 8'd40,  8'd220, 11'd1280, 6'd5,  4'd5, 6'd20, 11'd720, 1'b0, 1'b0};
         3:       return {7'd16,  8'd62,  8'd60,  11'd720,  6'd9,  4'd6, 6'd30, 11'd480, 1'b1, 1'b0};
         4:       return {7'd88,  8'd44,  8'd148, 11'd1920, 6'd2,  4'd5, 6'd15, 11'd540, 1'b0, 1'b1};
         default: return {7'd16,  8'd96,  8'd48,  11'd640,  6'd10, 4'd2, 6'd33, 11'd480, 1'b1, 1'b0};
      endcase
   endfunction

   // vSync level at which vAct is low for mode m
   function automatic logic idle_vs(input int m);
      return (m == 0 || m == 3);
   endfunction

   function automatic logic [62:0] act_vec();
      return {hFrontPorch, hSyncPulse, hBackPorch, hActive, vFrontPorch, vSyncPulse,
              vBackPorch, vActive, syncIsActiveLow, isInterlaced};
   endfunction

   always @(negedge pixelClock) begin
      if (!reset && modeChanged) begin
         int m;
         sb_tests++;
         if (exp_q.size() == 0) begin
            sb_fails++;
            $display("FAIL sb_unexpected_load: modeChanged with no expected load, mode=%0d", currentMode);
         end else begin
            m = exp_q.pop_front();
            if ({currentMode, act_vec()} !== {3'(m), exp_vec(m)}) begin
               sb_fails++;
               $display("FAIL sb_load: got mode=%0d params=%h, want mode=%0d params=%h",
                        currentMode, act_vec(), m, exp_vec(m));
            end
         end
      end
   end

   task automatic tick();
      @(posedge pixelClock);
      #1;
   endtask

   task automatic request(input int idx);
      modeSelect = 3'(idx);
      modeChangeRequest = 1'b1;
      tick();
      modeChangeRequest = 1'b0;
   endtask

   task automatic boundary(input logic act_level);
      sinkVSync = act_level;
      tick();
   endtask

   task automatic wait_run(output int n);
      n = 0;
      while (sinkReset && n < 100) begin
         n++;
         tick();
      end
   endtask

   task automatic test_reset();
      int n;
      tick(); tick();
      tests++;
      if ({sinkReset, busy, modeChanged, modeError, underrun} !== 5'b11000) begin
         fails++;
         $display("FAIL reset_flags: got %b want 11000", {sinkReset, busy, modeChanged, modeError, underrun});
      end
      tests++;
      if ({currentMode, act_vec(), lateCount} !== {3'd0, exp_vec(0), 16'd0}) begin
         fails++;
         $display("FAIL reset_params: got mode=%0d params=%h late=%0d", currentMode, act_vec(), lateCount);
      end
      exp_q.push_back(0);
      reset = 1'b0;
      wait_run(n);
      tests++;
      if (n !== 16) begin
         fails++;
         $display("FAIL reset_hold_len: got %0d cycles want 16", n);
      end
      tests++;
      if ({modeChanged, busy} !== 2'b10) begin
         fails++;
         $display("FAIL reset_first_run: got changed/busy=%b want 10", {modeChanged, busy});
      end
      tick();
      tests++;
      if (modeChanged !== 1'b0) begin
         fails++;
         $display("FAIL reset_pulse_width: got %b want 0", modeChanged);
      end
   endtask

   task automatic test_mode_change();
      int n;
      request(2);
      exp_q.push_back(2);
      tests++;
      if ({busy, sinkReset, hActive} !== {2'b10, 11'd640}) begin
         fails++;
         $display("FAIL change_wait: got busy=%b rst=%b hact=%0d want 1 0 640", busy, sinkReset, hActive);
      end
      repeat (3) tick();
      boundary(1'b0);
      tests++;
      if ({sinkReset, hActive, currentMode} !== {1'b1, 11'd1280, 3'd2}) begin
         fails++;
         $display("FAIL change_edge: got rst=%b hact=%0d mode=%0d want 1 1280 2", sinkReset, hActive, currentMode);
      end
      sinkVSync = idle_vs(2);
      wait_run(n);
      tests++;
      if (n !== 16 || modeChanged !== 1'b1) begin
         fails++;
         $display("FAIL change_hold_len: got %0d cycles changed=%b want 16 1", n, modeChanged);
      end
   endtask

   task automatic test_mode_error();
      int bad[$] = '{5, 6, 7};
`ifndef VIDEO_MODE_INTERLACE_EN
      bad.push_back(4);
`endif
      foreach (bad[i]) begin
         request(bad[i]);
         tests++;
         if ({modeError, busy} !== 2'b10) begin
            fails++;
            $display("FAIL error_pulse idx=%0d: got err/busy=%b want 10", bad[i], {modeError, busy});
         end
         tick();
         tests++;
         if ({modeError, busy, currentMode, act_vec()} !== {2'b00, 3'd2, exp_vec(2)}) begin
            fails++;
            $display("FAIL error_after idx=%0d: got err=%b busy=%b mode=%0d params=%h",
                     bad[i], modeError, busy, currentMode, act_vec());
         end
      end
   endtask

   task automatic test_timeout();
      int n;
      request(1);
      exp_q.push_back(1);
      n = 0;
      while (!sinkReset && n < 300) begin
         n++;
         tick();
      end
      tests++;
      if (n !== 100) begin
         fails++;
         $display("FAIL timeout_len: got %0d cycles want 100", n);
      end
      sinkVSync = idle_vs(1);
      wait_run(n);
      tests++;
      if (n !== 16) begin
         fails++;
         $display("FAIL timeout_hold_len: got %0d want 16", n);
      end
   endtask

   task automatic test_underrun();
      int lates[$] = '{3, 7, 0, 5, 5, 5, 5};
      int n;
      foreach (lates[k]) begin
         sinkLate = 1'b1;
         repeat (lates[k]) tick();
         sinkLate = 1'b0;
         repeat (3) tick();
         boundary(~idle_vs(1));
         sinkVSync = idle_vs(1);
         tests++;
         if ({lateCount, underrun} !== {16'(lates[k]), (k == 6) ? 1'b1 : 1'b0}) begin
            fails++;
            $display("FAIL underrun_frame%0d: got late=%0d ur=%b want %0d %b",
                     k, lateCount, underrun, lates[k], k == 6);
         end
         repeat (2) tick();
      end
      request(3);
      exp_q.push_back(3);
      tests++;
      if (underrun !== 1'b1) begin
         fails++;
         $display("FAIL underrun_sticky: got %b want 1", underrun);
      end
      boundary(~idle_vs(1));
      sinkVSync = idle_vs(3);
      tests++;
      if (underrun !== 1'b0) begin
         fails++;
         $display("FAIL underrun_clear: got %b want 0", underrun);
      end
      wait_run(n);
   endtask

   task automatic test_back_to_back();
      int n;
      request(3);
      exp_q.push_back(3);
      request(6);
      tests++;
      if ({modeError, busy, sinkReset} !== 3'b010) begin
         fails++;
         $display("FAIL wait_ignore_err: got err/busy/rst=%b want 010", {modeError, busy, sinkReset});
      end
      request(0);
      boundary(~idle_vs(3));
      sinkVSync = idle_vs(3);
      wait_run(n);
      repeat (20) tick();
      tests++;
      if ({n, currentMode, busy, act_vec()} !== {32'd16, 3'd3, 1'b0, exp_vec(3)}) begin
         fails++;
         $display("FAIL reload_same: got hold=%0d mode=%0d busy=%b want 16 3 0", n, currentMode, busy);
      end
   endtask

   task automatic test_reset_in_wait();
      int n;
      int bad_cyc = 0;
      request(1);
      tick(); tick();
      #2 reset = 1'b1;
      #1;
      tests++;
      if ({sinkReset, busy, currentMode, act_vec(), underrun} !== {2'b11, 3'd0, exp_vec(0), 1'b0}) begin
         fails++;
         $display("FAIL async_reset: got rst=%b busy=%b mode=%0d params=%h",
                  sinkReset, busy, currentMode, act_vec());
      end
      exp_q.delete();
      exp_q.push_back(0);
      sinkVSync = idle_vs(0);
      tick();
      reset = 1'b0;
      wait_run(n);
      tests++;
      if (n !== 16) begin
         fails++;
         $display("FAIL reset_wait_hold: got %0d want 16", n);
      end
      repeat (150) begin
         tick();
         if (currentMode !== 3'd0 || busy !== 1'b0) bad_cyc++;
      end
      tests++;
      if (bad_cyc !== 0) begin
         fails++;
         $display("FAIL reset_lost_request: got %0d cycles off default want 0", bad_cyc);
      end
   endtask

   initial begin
      test_reset();
      test_mode_change();
      test_mode_error();
      test_timeout();
      test_underrun();
      test_back_to_back();
      test_reset_in_wait();
      repeat (3) tick();
      tests++;
      if (exp_q.size() !== 0) begin
         fails++;
         $display("FAIL sb_pending: got %0d loads outstanding want 0", exp_q.size());
      end
      tests += sb_tests;
      fails += sb_fails;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
